pprm_sbox_sequencer: RTL and testbench

Sequences a 16-byte (parameterizable) AES state through one shared PPRM S-box datapath, one byte per cycle. The datapath is the three-stage PPRM GF(2^8) inverter (stage 1 → stage 2 → stage 3) plus the output affine transform. The block captures a block on a start handshake, issues bytes in order, and collects results into an output register. It pulses `done` when the last substituted byte has been written. It sits between the round controller and the SubBytes/key-schedule datapath, replacing 16 parallel S-box instances with one time-shared instance.

---
 rtl/pprm_sbox_sequencer_if.sv | 22 ++
 rtl/pprm_sbox_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_pprm_sbox_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pprm_sbox_sequencer_if.sv
// Handshake and block bus between the round controller and the
// time-shared S-box sequencer.
interface pprm_sbox_sequencer_if #(
  parameter int NUM_BYTES = 16
);
  logic                   start;
  logic [8*NUM_BYTES-1:0] block_in;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [8*NUM_BYTES-1:0] block_out;

  modport master (
    output start, block_in,
    input  ready, busy, done, block_out
  );

  modport slave (
    input  start, block_in,
    output ready, busy, done, block_out
  );
endinterface

// File: rtl/pprm_sbox_sequencer.sv
// One shared PPRM S-box sequenced over an AES block, a byte per cycle.
// Define PPRM_PIPELINE_EN for the 3-cycle registered datapath.
module pprm_sbox_sequencer #(
  parameter int NUM_BYTES = 16
) (
  input logic                  clk,
  input logic                  rst,
  pprm_sbox_sequencer_if.slave bus
);

  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int W  = 8 * NUM_BYTES;
`ifdef PPRM_PIPELINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int DRN = (LAT > 1) ? LAT - 2 : 0;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
  localparam logic [8:0] POLY = 9'h11b;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  // GF(2^4) over x^4+x+1
  function automatic logic [3:0] gf4_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] r;
    logic [3:0] x;
    r = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  // a^14 is the inverse in GF(16); maps 0 to 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] r;
    logic [3:0] p;
    logic [3:0] e;
    r = 4'h1;
    p = a;
    e = 4'he;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) r = gf4_mul(r, p);
      p = gf4_mul(p, p);
    end
    return r;
  endfunction

  // tower element {h,l} = h*y + l with y^2 = y + lam
  function automatic logic [7:0] twr_mul(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] lam
  );
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = gf4_mul(a[7:4], b[7:4]);
    hi = hh ^ gf4_mul(a[7:4], b[3:0])
            ^ gf4_mul(a[3:0], b[7:4]);
    lo = gf4_mul(hh, lam) ^ gf4_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  // smallest lam keeping y^2+y+lam irreducible
  function automatic logic [3:0] find_lam();
    logic [3:0] r;
    logic       hit;
    logic [3:0] t;
    r = 4'h0;
    for (int c = 15; c >= 1; c--) begin
      hit = 1'b0;
      for (int i = 0; i < 16; i++) begin
        t = 4'(i);
        if ((gf4_mul(t, t) ^ t) == 4'(c)) hit = 1'b1;
      end
      if (!hit) r = 4'(c);
    end
    return r;
  endfunction

  // a tower-field root of the AES polynomial
  function automatic logic [7:0] find_root(input logic [3:0] lam);
    logic [7:0] r;
    logic [7:0] pw;
    logic [7:0] acc;
    r = 8'h00;
    for (int c = 255; c >= 2; c--) begin
      pw  = 8'h01;
      acc = 8'h00;
      for (int i = 0; i < 9; i++) begin
        if (POLY[i]) acc = acc ^ pw;
        pw = twr_mul(pw, 8'(c), lam);
      end
      if (acc == 8'h00) r = 8'(c);
    end
    return r;
  endfunction

  // column i of the map is the image of basis bit i
  function automatic logic [7:0] lin_map(
    input logic [63:0] m,
    input logic [7:0]  a
  );
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (a[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] iso_fwd(
    input logic [7:0] g,
    input logic [3:0] lam
  );
    logic [63:0] m;
    logic [7:0]  pw;
    m  = '0;
    pw = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = pw;
      pw = twr_mul(pw, g, lam);
    end
    return m;
  endfunction

  function automatic logic [63:0] iso_inv(input logic [63:0] m);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++)
      for (int a = 0; a < 256; a++)
        if (lin_map(m, 8'(a)) == (8'h01 << j))
          r[8*j +: 8] = 8'(a);
    return r;
  endfunction

  localparam logic [3:0]  LAM  = find_lam();
  localparam logic [7:0]  ROOT = find_root(LAM);
  localparam logic [63:0] TO_T = iso_fwd(ROOT, LAM);
  localparam logic [63:0] TO_A = iso_inv(TO_T);

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
  endfunction

  // stage 1: map to tower, norm d plus A/B nibbles
  function automatic logic [11:0] stg1(input logic [7:0] x);
    logic [7:0] t;
    logic [3:0] d;
    t = lin_map(TO_T, x);
    d = gf4_mul(gf4_mul(t[7:4], t[7:4]), LAM)
      ^ gf4_mul(t[7:4], t[3:0])
      ^ gf4_mul(t[3:0], t[3:0]);
    return {d, t};
  endfunction

  // stage 2: 4-bit inverse of the norm
  function automatic logic [11:0] stg2(input logic [11:0] s);
    return {gf4_inv(s[11:8]), s[7:0]};
  endfunction

  // stage 3: recombine, map back, affine
  function automatic logic [7:0] stg3(input logic [11:0] s);
    logic [7:0] t;
    t = {gf4_mul(s[7:4], s[11:8]),
         gf4_mul(s[7:4] ^ s[3:0], s[11:8])};
    return affine(lin_map(TO_A, t));
  endfunction

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] drn_q, drn_d;
  logic [W-1:0]  in_q;
  logic [W-1:0]  out_q;

  logic          iss_v;
  logic [7:0]    iss_b;
  logic          res_v;
  logic [CW-1:0] res_t;
  logic [7:0]    res_b;
  logic          rdy, bsy, dn;

  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      drn_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      drn_q <= drn_d;
    end
  end

  // next state: feed bytes, drain pipe, pulse done
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    drn_d = drn_q;
    unique case (st_q)
      S_IDLE: begin
        if (bus.start) begin
          st_d  = S_FEED;
          cnt_d = '0;
        end
      end
      S_FEED: begin
        if (cnt_q == LAST) begin
          if (LAT > 1) begin
            st_d  = S_DRAIN;
            drn_d = CW'(DRN);
          end else begin
            st_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) st_d = S_DONE;
        else drn_d = drn_q - CW'(1);
      end
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // status outputs and byte issue select
  always_comb begin
    rdy   = (st_q == S_IDLE);
    bsy   = (st_q != S_IDLE);
    dn    = (st_q == S_DONE);
    iss_v = (st_q == S_FEED);
    iss_b = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++)
      if (cnt_q == CW'(k)) iss_b = in_q[8*k +: 8];
  end

  // capture the block only at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= '0;
    else if (st_q == S_IDLE && bus.start) in_q <= bus.block_in;
  end

`ifdef PPRM_PIPELINE_EN
  logic [11:0]   s1_q, s2_q;
  logic          s1_v_q, s2_v_q;
  logic [CW-1:0] s1_t_q, s2_t_q;

  // stage registers carry data, valid and byte tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s1_v_q <= 1'b0;
      s1_t_q <= '0;
      s2_q   <= '0;
      s2_v_q <= 1'b0;
      s2_t_q <= '0;
    end else begin
      s1_q   <= stg1(iss_b);
      s1_v_q <= iss_v;
      s1_t_q <= cnt_q;
      s2_q   <= stg2(s1_q);
      s2_v_q <= s1_v_q;
      s2_t_q <= s1_t_q;
    end
  end

  assign res_v = s2_v_q;
  assign res_t = s2_t_q;
  assign res_b = stg3(s2_q);
`else
  assign res_v = iss_v;
  assign res_t = cnt_q;
  assign res_b = stg3(stg2(stg1(iss_b)));
`endif

  // write each result into the byte named by its tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BYTES; k++)
        if (res_v && res_t == CW'(k))
          out_q[8*k +: 8] <= res_b;
    end
  end

  assign bus.ready     = rdy;
  assign bus.busy      = bsy;
  assign bus.done      = dn;
  assign bus.block_out = out_q;

endmodule

// File: tb/tb_pprm_sbox_sequencer.sv
// Bench for pprm_sbox_sequencer: 16-byte and 4-byte instances,
// scoreboard of expected blocks checked at each done pulse.
module tb_pprm_sbox_sequencer;

`ifdef PPRM_PIPELINE_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pprm_sbox_sequencer_if #(.NUM_BYTES(16)) b16 ();
  pprm_sbox_sequencer_if #(.NUM_BYTES(4))  b4 ();

  pprm_sbox_sequencer #(.NUM_BYTES(16)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  pprm_sbox_sequencer #(.NUM_BYTES(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_m(logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_blk(logic [127:0] b, int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = sbox_m(b[8*k +: 8]);
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] obs_out(bit s4);
    return s4 ? 128'(b4.block_out) : b16.block_out;
  endfunction

  function automatic logic [2:0] obs_st(bit s4);
    return s4 ? {b4.ready, b4.busy, b4.done}
              : {b16.ready, b16.busy, b16.done};
  endfunction

  task automatic drive(bit s4, logic [127:0] blk, logic st);
    if (s4) begin
      b4.block_in = blk[31:0];
      b4.start    = st;
    end else begin
      b16.block_in = blk;
      b16.start    = st;
    end
  endtask

  // called at a negedge with start low
  task automatic run(bit s4, logic [127:0] blk, string tag);
    int t0;
    int nb;
    bit ok;
    logic [127:0] e;
    nb = s4 ? 4 : 16;
    drive(s4, blk, 1'b1);
    t0 = cyc;
    exp_q.push_back(sub_blk(blk, nb));
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      drive(s4, blk, 1'b0);
      if (obs_st(s4)[0]) ok = 1'b1;
    end
    chk({tag, "_done_seen"}, 128'(ok), 128'(1));
    chk({tag, "_latency"}, 128'(cyc - t0), 128'(nb + L));
    e = exp_q.pop_front();
    chk({tag, "_block"}, obs_out(s4), e);
    @(negedge clk);
    chk({tag, "_after_done"}, 128'(obs_st(s4)), 128'(3'b100));
  endtask

  initial begin
    logic [127:0] blk;
    logic [127:0] blk_b;
    logic [127:0] e;
    int t0, c1, c2, tgt;
    bit ok;

    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_st16", 128'(obs_st(1'b0)), 128'(3'b100));
    chk("rst_out16", obs_out(1'b0), '0);
    chk("rst_st4", 128'(obs_st(1'b1)), 128'(3'b100));
    chk("rst_out4", obs_out(1'b1), '0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, '0, "zero16");
    chk("zero16_lit", obs_out(1'b0), {16{8'h63}});

    for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(k);
    run(1'b0, blk, "ramp16");
    chk("ramp16_lit", obs_out(1'b0),
        128'h76abd7fe2b670130c56f6bf27b777c63);

    run(1'b1, 128'(32'hff530100), "sw4");
    chk("sw4_lit", obs_out(1'b1), 128'(32'h16ed7c63));

    // start held high; block_in changed during FEED
    blk   = {4{32'hdeadbeef}};
    blk_b = {4{32'h01234567}};
    drive(1'b0, blk, 1'b1);
    t0 = cyc;
    exp_q.push_back(sub_blk(blk, 16));
    @(negedge clk);
    drive(1'b0, blk_b, 1'b1);
    exp_q.push_back(sub_blk(blk_b, 16));
    ok = 1'b0;
    c1 = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (b16.done) begin
        ok = 1'b1;
        c1 = cyc;
      end
    end
    chk("hold_done1_seen", 128'(ok), 128'(1));
    chk("hold_done1_lat", 128'(c1 - t0), 128'(16 + L));
    e = exp_q.pop_front();
    chk("hold_block1", b16.block_out, e);
    ok = 1'b0;
    c2 = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (b16.done) begin
        ok = 1'b1;
        c2 = cyc;
      end
    end
    drive(1'b0, blk_b, 1'b0);
    chk("hold_done2_seen", 128'(ok), 128'(1));
    chk("hold_gap", 128'(c2 - c1), 128'(16 + L + 1));
    e = exp_q.pop_front();
    chk("hold_block2", b16.block_out, e);
    repeat (2) @(negedge clk);

    // async reset while bytes are in flight
    blk = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b0, blk, 1'b1);
    t0 = cyc;
    @(negedge clk);
    drive(1'b0, blk, 1'b0);
    tgt = (L > 1) ? t0 + 17 : t0 + 8;
    while (cyc < tgt) @(negedge clk);
    chk("pre_rst_busy", 128'(obs_st(1'b0)), 128'(3'b010));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_st", 128'(obs_st(1'b0)), 128'(3'b100));
    chk("async_rst_out", b16.block_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_out", b16.block_out, '0);
    chk("post_rst_st", 128'(obs_st(1'b0)), 128'(3'b100));
    run(1'b0, {4{32'hc0ffee11}}, "post_rst");

    // every byte value once across 16 blocks
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(16 * j + k);
      run(1'b0, blk, $sformatf("sweep%0d", j));
    end

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
